// File: rtl/conv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// conv_ctrl_pkg
// Command/ack encodings, sequencer states and default geometry shared by the
// convolution layer sequencer.
// Revision: 1.0
// ============================================================================
package conv_ctrl_pkg;

  localparam int DEF_NUM_KERNEL = 3;
  localparam int DEF_NUM_ROW    = 6;

  localparam logic [1:0] CMD_IDLE    = 2'd0;
  localparam logic [1:0] CMD_PRELOAD = 2'd1;
  localparam logic [1:0] CMD_SHIFT   = 2'd2;
  localparam logic [1:0] CMD_LOAD    = 2'd3;

  localparam logic [1:0] ACK_NONE        = 2'd0;
  localparam logic [1:0] ACK_PRELOAD_FIN = 2'd1;
  localparam logic [1:0] ACK_SHIFT_FIN   = 2'd2;
  localparam logic [1:0] ACK_LOAD_FIN    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRELOAD = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_LOAD    = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/conv_tag_pipe.sv
`default_nettype none
// ============================================================================
// conv_tag_pipe
// PIPE_LAT-deep valid+tag delay line with synchronous flush of the valid bits.
// Revision: 1.0
// ============================================================================
module conv_tag_pipe #(
  parameter int PIPE_LAT = 3,
  parameter int TAG_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic             drain_empty
);

  logic [PIPE_LAT-1:0] r_valid;
  logic [TAG_W-1:0]    r_tag [PIPE_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < PIPE_LAT; i++) r_tag[i] <= '0;
    end else begin
      for (int i = PIPE_LAT - 1; i > 0; i--) begin
        r_valid[i] <= r_valid[i-1] & ~flush;
        r_tag[i]   <= r_tag[i-1];
      end
      r_valid[0] <= in_valid & ~flush;
      r_tag[0]   <= in_tag;
    end
  end

  assign out_valid = r_valid[PIPE_LAT-1];
  assign out_tag   = r_tag[PIPE_LAT-1];

  // True when nothing sits behind the output stage: the pipe is empty next cycle.
  if (PIPE_LAT > 1) begin : g_multi
    assign drain_empty = ~|r_valid[PIPE_LAT-2:0];
  end else begin : g_single
    assign drain_empty = 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/conv_layer_sequencer.sv
`default_nettype none
// ============================================================================
// conv_layer_sequencer
// Issues PRELOAD/SHIFT/LOAD over kernels and rows, tags each result in flight.
// Revision: 1.0
// ============================================================================
module conv_layer_sequencer
  import conv_ctrl_pkg::*;
#(
  parameter int NUM_KERNEL = DEF_NUM_KERNEL,
  parameter int NUM_ROW    = DEF_NUM_ROW,
  parameter int PIPE_LAT   = 3,
  parameter int KIDX_W     = (NUM_KERNEL > 1) ? $clog2(NUM_KERNEL) : 1,
  parameter int ROW_W      = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              cfg_continuous,
  input  logic              out_ready,
  input  logic [1:0]        in_ack,
  output logic [1:0]        in_cmd,
  output logic              busy,
  output logic              out_valid,
  output logic [KIDX_W-1:0] out_kernel,
  output logic [ROW_W-1:0]  out_row,
  output logic              out_last,
  output logic              frame_done,
  output logic              err_ack
);

  localparam int                c_tag_w     = 1 + ROW_W + KIDX_W;
  localparam logic [KIDX_W-1:0] c_kidx_last = KIDX_W'(NUM_KERNEL - 1);
  localparam logic [ROW_W-1:0]  c_row_last  = ROW_W'(NUM_ROW - 1);

  state_t              r_state, w_state_nxt;
  logic [KIDX_W-1:0]   r_kidx, w_kidx_nxt;
  logic [ROW_W-1:0]    r_row, w_row_nxt;
  logic                r_pending, w_pending_nxt;
  logic [1:0]          r_cmd, w_cmd_nxt;
  logic                r_err, w_err_nxt;
  logic                w_push, w_shift_req, w_push_last;
  logic                w_pipe_valid, w_drain_empty, w_tag_last;
  logic [c_tag_w-1:0]  w_pipe_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_kidx    <= '0;
      r_row     <= '0;
      r_pending <= 1'b0;
      r_cmd     <= CMD_IDLE;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_kidx    <= w_kidx_nxt;
      r_row     <= w_row_nxt;
      r_pending <= w_pending_nxt;
      r_cmd     <= w_cmd_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign w_push_last = (r_kidx == c_kidx_last) && (r_row == c_row_last);

  always_comb begin
    w_state_nxt   = r_state;
    w_kidx_nxt    = r_kidx;
    w_row_nxt     = r_row;
    w_pending_nxt = r_pending;
    w_cmd_nxt     = CMD_IDLE;
    w_err_nxt     = r_err;
    w_push        = 1'b0;
    w_shift_req   = 1'b0;
    if (abort) begin
      w_state_nxt   = ST_IDLE;
      w_kidx_nxt    = '0;
      w_row_nxt     = '0;
      w_pending_nxt = 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_state_nxt = ST_PRELOAD;
            w_cmd_nxt   = CMD_PRELOAD;
            w_err_nxt   = 1'b0;
          end
          if (in_ack != ACK_NONE) w_err_nxt = 1'b1;
        end
        ST_PRELOAD: begin
          if (in_ack == ACK_PRELOAD_FIN) begin
            w_state_nxt = ST_SHIFT;
            w_shift_req = 1'b1;
          end else if (in_ack != ACK_NONE) w_err_nxt = 1'b1;
        end
        ST_LOAD: begin
          if (in_ack == ACK_LOAD_FIN) begin
            w_state_nxt = ST_SHIFT;
            w_shift_req = 1'b1;
          end else if (in_ack != ACK_NONE) w_err_nxt = 1'b1;
        end
        ST_SHIFT: begin
          // A SHIFT_FIN only counts once the SHIFT it answers has been issued.
          if (r_pending) begin
            if (in_ack != ACK_NONE) w_err_nxt = 1'b1;
            if (out_ready) begin
              w_cmd_nxt     = CMD_SHIFT;
              w_pending_nxt = 1'b0;
            end
          end else if (in_ack == ACK_SHIFT_FIN) begin
            w_push = 1'b1;
            if (r_kidx != c_kidx_last) begin
              w_kidx_nxt  = r_kidx + 1'b1;
              w_shift_req = 1'b1;
            end else begin
              w_kidx_nxt = '0;
              if (r_row != c_row_last) begin
                w_row_nxt   = r_row + 1'b1;
                w_cmd_nxt   = CMD_LOAD;
                w_state_nxt = ST_LOAD;
              end else begin
                w_row_nxt = '0;
                if (cfg_continuous) begin
                  w_cmd_nxt   = CMD_PRELOAD;
                  w_state_nxt = ST_PRELOAD;
                end else begin
                  w_state_nxt = ST_DRAIN;
                end
              end
            end
          end else if (in_ack != ACK_NONE) w_err_nxt = 1'b1;
        end
        ST_DRAIN: begin
          if (w_drain_empty) w_state_nxt = ST_IDLE;
          if (in_ack != ACK_NONE) w_err_nxt = 1'b1;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
      if (w_shift_req) begin
        if (out_ready) begin
          w_cmd_nxt     = CMD_SHIFT;
          w_pending_nxt = 1'b0;
        end else begin
          w_pending_nxt = 1'b1;
        end
      end
    end
  end

  conv_tag_pipe #(
    .PIPE_LAT (PIPE_LAT),
    .TAG_W    (c_tag_w)
  ) u_tag_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (abort),
    .in_valid    (w_push),
    .in_tag      ({w_push_last, r_row, r_kidx}),
    .out_valid   (w_pipe_valid),
    .out_tag     (w_pipe_tag),
    .drain_empty (w_drain_empty)
  );

  assign {w_tag_last, out_row, out_kernel} = w_pipe_tag;
  assign out_valid  = w_pipe_valid;
  assign out_last   = w_pipe_valid & w_tag_last;
  assign frame_done = w_pipe_valid & w_tag_last;
  assign busy       = (r_state != ST_IDLE);
  assign in_cmd     = r_cmd;
  assign err_ack    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_sequencer.sv
`default_nettype none
// ============================================================================
// tb_conv_layer_sequencer
// Vector table, directed corner sequences and random traffic against a model.
// Revision: 1.0
// ============================================================================
module tb_conv_layer_sequencer;
  import conv_ctrl_pkg::*;

  localparam int NK = 3;
  localparam int NR = 2;
  localparam int PL = 3;

  logic       clk, rst_n, start, abort, cfg_continuous, out_ready;
  logic [1:0] in_ack, in_cmd;
  logic       busy, out_valid, out_last, frame_done, err_ack;
  logic [1:0] out_kernel;
  logic [0:0] out_row;

  conv_layer_sequencer #(.NUM_KERNEL(NK), .NUM_ROW(NR), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_continuous(cfg_continuous), .out_ready(out_ready), .in_ack(in_ack),
    .in_cmd(in_cmd), .busy(busy), .out_valid(out_valid), .out_kernel(out_kernel),
    .out_row(out_row), .out_last(out_last), .frame_done(frame_done), .err_ack(err_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int k; int r; } tag_t;
  typedef struct { int t; int k; int r; int last; } due_t;
  tag_t tag_q[$];
  due_t due_q[$];
  int   now, exp_cmd, ack_at, ack_val, ack_lo, ack_hi;
  bit   want_shift, frame_open, m_err, ack_pend, exp_busy_now;
  int   sf_cnt, shift_cnt, shift3_at, done_cnt, busy_low, hold_sf, hold_until, sf2_at, abort_sf;

  task automatic fill_frame();
    for (int r = 0; r < NR; r++)
      for (int k = 0; k < NK; k++) tag_q.push_back('{k, r});
  endtask

  task automatic model_reset();
    tag_q.delete(); due_q.delete();
    exp_cmd = 0; want_shift = 0; frame_open = 0; m_err = 0; ack_pend = 0;
    exp_busy_now = 0; hold_until = -1; hold_sf = 0; abort_sf = 0;
  endtask

  task automatic check_outputs();
    due_t d;
    chk("in_cmd", int'(in_cmd), exp_cmd);
    exp_busy_now = frame_open || (due_q.size() > 0);
    chk("busy", int'(busy), int'(exp_busy_now));
    if (due_q.size() > 0 && due_q[0].t == now) begin
      d = due_q.pop_front();
      chk("out_valid", int'(out_valid), 1);
      chk("out_kernel", int'(out_kernel), d.k);
      chk("out_row", int'(out_row), d.r);
      chk("out_last", int'(out_last), d.last);
      chk("frame_done", int'(frame_done), d.last);
      if (d.last != 0) done_cnt++;
    end else begin
      chk("out_valid_idle", int'(out_valid), 0);
      chk("frame_done_idle", int'(frame_done), 0);
    end
    chk("err_ack", int'(err_ack), int'(m_err));
    if (!busy) busy_low++;
    if (in_cmd == CMD_SHIFT) begin
      shift_cnt++;
      if (shift_cnt == 3) shift3_at = now;
    end
    // Responder: answer each observed command with its matching FIN.
    if (in_cmd != CMD_IDLE) begin
      ack_pend = 1;
      ack_at   = now + int'($urandom_range(ack_hi, ack_lo));
      ack_val  = int'(in_cmd);
    end
  endtask

  task automatic cycle(input bit st, input bit ab_req, input bit rdy_in, input bit cont, input bit bad);
    int   ack, nxt;
    bit   ab, rdy;
    tag_t tg;
    rdy = rdy_in;
    ack = (ack_pend && ack_at == now) ? ack_val : 0;
    if (ack_pend && ack_at == now) ack_pend = 0;
    ab = ab_req;
    if (abort_sf > 0 && ack == 2 && sf_cnt + 1 == abort_sf) begin ab = 1; abort_sf = 0; end
    if (hold_sf > 0 && !ab && ack == 2 && sf_cnt + 1 == hold_sf) begin
      hold_until = now + 4; sf2_at = now; hold_sf = 0;
    end
    if (now <= hold_until) rdy = 0;
    if (bad) ack = int'(ACK_LOAD_FIN);
    start = st; abort = ab; out_ready = rdy; cfg_continuous = cont; in_ack = ack[1:0];
    nxt = 0;
    if (ab) begin
      frame_open = 0; want_shift = 0; tag_q.delete(); due_q.delete(); ack_pend = 0;
    end else begin
      if (st && !exp_busy_now) begin frame_open = 1; m_err = 0; nxt = 1; fill_frame(); end
      if (bad) m_err = 1;
      else if (ack == 1 || ack == 3) want_shift = 1;
      else if (ack == 2) begin
        sf_cnt++;
        if (tag_q.size() == 0) chk("unexpected_shift_fin", 1, 0);
        else begin
          tg = tag_q.pop_front();
          due_q.push_back('{now + PL, tg.k, tg.r, int'(tg.k == NK-1 && tg.r == NR-1)});
          if (tg.k < NK-1) want_shift = 1;
          else if (tg.r < NR-1) nxt = 3;
          else if (cont) begin nxt = 1; fill_frame(); end
          else frame_open = 0;
        end
      end
      if (want_shift && rdy) begin nxt = 2; want_shift = 0; end
    end
    @(posedge clk); #1;
    now++;
    exp_cmd = nxt;
    check_outputs();
  endtask

  task automatic run_until_done(input int target, input bit cont);
    for (int i = 0; i < 300 && done_cnt < target; i++) cycle(0, 0, 1, cont, 0);
    chk("frame_timeout", done_cnt, target);
  endtask

  // ---------------- vector table: one plain frame ----------------
  typedef struct { int st; int ack; int cmd; int busy; int v; int k; int r; int last; } vec_t;
  vec_t tbl[20];

  initial begin
    int d0, b0;
    tbl = '{
      '{1,0, 1,1,0,0,0,0}, '{0,0, 0,1,0,0,0,0}, '{0,1, 2,1,0,0,0,0}, '{0,0, 0,1,0,0,0,0},
      '{0,2, 2,1,0,0,0,0}, '{0,0, 0,1,0,0,0,0}, '{0,2, 2,1,1,0,0,0}, '{0,0, 0,1,0,0,0,0},
      '{0,2, 3,1,1,1,0,0}, '{0,0, 0,1,0,0,0,0}, '{0,3, 2,1,1,2,0,0}, '{0,0, 0,1,0,0,0,0},
      '{0,2, 2,1,0,0,0,0}, '{0,0, 0,1,0,0,0,0}, '{0,2, 2,1,1,0,1,0}, '{0,0, 0,1,0,0,0,0},
      '{0,2, 0,1,1,1,1,0}, '{0,0, 0,1,0,0,0,0}, '{0,0, 0,1,1,2,1,1}, '{0,0, 0,0,0,0,0,0}
    };
    rst_n = 0; start = 0; abort = 0; cfg_continuous = 0; out_ready = 1; in_ack = 0;
    now = 0; sf_cnt = 0; shift_cnt = 0; shift3_at = -1; done_cnt = 0; busy_low = 0;
    ack_lo = 1; ack_hi = 1; sf2_at = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_cmd", int'(in_cmd), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_err", int'(err_ack), 0);
    rst_n = 1;

    for (int i = 0; i < 20; i++) begin
      start = tbl[i].st[0]; in_ack = tbl[i].ack[1:0];
      @(posedge clk); #1;
      now++;
      chk("tbl_cmd", int'(in_cmd), tbl[i].cmd);
      chk("tbl_busy", int'(busy), tbl[i].busy);
      chk("tbl_valid", int'(out_valid), tbl[i].v);
      chk("tbl_done", int'(frame_done), tbl[i].last);
      if (tbl[i].v != 0) begin
        chk("tbl_kernel", int'(out_kernel), tbl[i].k);
        chk("tbl_row", int'(out_row), tbl[i].r);
        chk("tbl_last", int'(out_last), tbl[i].last);
      end
    end
    start = 0; in_ack = 0;

    // Back-pressure after the second SHIFT_FIN.
    model_reset(); sf_cnt = 0; shift_cnt = 0; hold_sf = 2;
    cycle(1, 0, 1, 0, 0);
    run_until_done(1, 0);
    chk("hold_shift3_time", shift3_at, sf2_at + 6);
    repeat (3) cycle(0, 0, 1, 0, 0);

    // Continuous mode: two back-to-back frames without a second start.
    d0 = done_cnt;
    cycle(1, 0, 1, 1, 0);
    b0 = busy_low;
    run_until_done(d0 + 1, 1);
    run_until_done(d0 + 2, 0);
    chk("cont_busy_gap", busy_low - b0, 0);
    repeat (3) cycle(0, 0, 1, 0, 0);

    // Abort alongside the fourth SHIFT_FIN, then a clean restart.
    d0 = done_cnt; sf_cnt = 0; abort_sf = 4;
    cycle(1, 0, 1, 0, 0);
    repeat (25) cycle(0, 0, 1, 0, 0);
    chk("abort_no_done", done_cnt, d0);
    chk("abort_busy", int'(busy), 0);
    cycle(1, 0, 1, 0, 0);
    run_until_done(d0 + 1, 0);
    repeat (3) cycle(0, 0, 1, 0, 0);

    // Stray LOAD_FIN while a SHIFT is outstanding.
    ack_lo = 2; ack_hi = 2; shift_cnt = 0; d0 = done_cnt;
    cycle(1, 0, 1, 0, 0);
    for (int i = 0; i < 20 && shift_cnt == 0; i++) cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 1);
    run_until_done(d0 + 1, 0);
    repeat (3) cycle(0, 0, 1, 0, 0);
    chk("err_sticky", int'(err_ack), 1);
    cycle(1, 0, 1, 0, 0);
    run_until_done(d0 + 2, 0);
    repeat (3) cycle(0, 0, 1, 0, 0);

    // Randomised traffic.
    ack_lo = 1; ack_hi = 3;
    for (int i = 0; i < 1500; i++)
      cycle(($urandom_range(3, 0) == 0), ($urandom_range(199, 0) == 0),
            ($urandom_range(3, 0) != 0), ($urandom_range(2, 0) == 0), 0);

    // Asynchronous reset in the middle of a frame.
    ack_lo = 1; ack_hi = 1;
    repeat (6) cycle(0, 0, 1, 0, 0);
    while (exp_busy_now) cycle(0, 1, 1, 0, 0);
    cycle(1, 0, 1, 0, 0);
    repeat (10) cycle(0, 0, 1, 0, 0);
    #2 rst_n = 0;
    #1;
    chk("arst_cmd", int'(in_cmd), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_last", int'(out_last), 0);
    chk("arst_done", int'(frame_done), 0);
    chk("arst_kernel", int'(out_kernel), 0);
    chk("arst_row", int'(out_row), 0);
    chk("arst_err", int'(err_ack), 0);
    start = 0; abort = 0; in_ack = 0;
    model_reset();
    #1 rst_n = 1;
    d0 = done_cnt;
    cycle(1, 0, 1, 0, 0);
    run_until_done(d0 + 1, 0);
    repeat (3) cycle(0, 0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
